// File: rtl/cfg_write_scheduler_pkg.sv
// Shared definitions for the configuration-register write scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cfg_pkg;

  // Default geometry of the configuration register bank.
  localparam int CFG_NUM_REGISTERS = 7;
  localparam int CFG_LEN_REGISTER  = 8;
  localparam int CFG_FIFO_DEPTH    = 4;
  localparam int CFG_AW            = $clog2(CFG_NUM_REGISTERS);

  // Register map.
  localparam int REG_COLOR1   = 0;
  localparam int REG_COLOR2   = 1;
  localparam int REG_COLOR3   = 2;
  localparam int REG_COLOR4   = 3;
  localparam int REG_SPRITE_X = 4;
  localparam int REG_SPRITE_Y = 5;
  localparam int REG_MISC     = 6;

  // One queued register write, sized for the default geometry.
  typedef struct packed {
    logic [CFG_AW-1:0]           addr;
    logic [CFG_LEN_REGISTER-1:0] data;
  } cfg_wr_t;

  // Requester identity, used for the round-robin pointer.
  typedef enum logic {
    REQ_SPI  = 1'b0,
    REQ_ANIM = 1'b1
  } req_id_e;

endpackage

// File: rtl/cfg_write_scheduler_fifo.sv
// Generic synchronous FIFO: push/pop with registered occupancy count.
// Latency: a push in cycle N is visible at the head and in count at N+1.
// Backpressure: push ignored while full, pop ignored while empty; the caller gates on full/empty.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push/push_data write
// side; pop/pop_data read side (pop_data is the current head, combinational);
// full/empty/count registered status.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/cfg_write_scheduler.sv
// Round-robin arbiter between SPI and animation config writes, buffered and committed one per cycle.
// Latency: handshake at N -> pending at N+1 -> earliest bank write strobe at N+2.
// Backpressure: ready only to the granted valid requester; both readys low while the FIFO is full.
//
// Ports: spi_*/anim_* valid-ready requesters (addr, data); vblank_i and
// sync_en_i gate commits to the blanking interval; wr_en_o/wr_addr_o/wr_data_o
// drive the bank's single write port; pending_o is the queued write count;
// err_o is sticky for accepted out-of-range addresses, cleared by err_clr_i.
module cfg_write_scheduler
  import cfg_pkg::*;
#(
  parameter  int NUM_REGISTERS = CFG_NUM_REGISTERS,
  parameter  int LEN_REGISTER  = CFG_LEN_REGISTER,
  parameter  int FIFO_DEPTH    = CFG_FIFO_DEPTH,
  localparam int AW            = $clog2(NUM_REGISTERS),
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    spi_valid_i,
  output logic                    spi_ready_o,
  input  logic [AW-1:0]           spi_addr_i,
  input  logic [LEN_REGISTER-1:0] spi_data_i,

  input  logic                    anim_valid_i,
  output logic                    anim_ready_o,
  input  logic [AW-1:0]           anim_addr_i,
  input  logic [LEN_REGISTER-1:0] anim_data_i,

  input  logic                    vblank_i,
  input  logic                    sync_en_i,
  input  logic                    err_clr_i,

  output logic                    wr_en_o,
  output logic [AW-1:0]           wr_addr_o,
  output logic [LEN_REGISTER-1:0] wr_data_o,
  output logic [CW-1:0]           pending_o,
  output logic                    err_o
);

  typedef struct packed {
    logic [AW-1:0]           addr;
    logic [LEN_REGISTER-1:0] data;
  } wr_t;

  localparam logic [AW:0] NREG = (AW+1)'(NUM_REGISTERS);

  req_id_e                 last;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic                    spi_gnt;
  logic                    anim_gnt;
  logic                    hs;
  logic                    addr_ok;
  logic                    push;
  logic                    pop;
  logic                    err_set;
  wr_t                     sel;
  wr_t                     head;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [LEN_REGISTER-1:0] wr_data;
  logic                    err;

  // Arbitration. full comes from the registered count, so a pop this cycle
  // cannot open a slot for a push in the same cycle. On a tie the requester
  // that did not win last time is granted; the two grants are exclusive.
  always_comb begin
    spi_gnt  = spi_valid_i  && !full && (!anim_valid_i || (last == REQ_ANIM));
    anim_gnt = anim_valid_i && !full && (!spi_valid_i  || (last == REQ_SPI));
  end

  always_comb begin
    sel = '0;
    if (anim_gnt) begin
      sel.addr = anim_addr_i;
      sel.data = anim_data_i;
    end else begin
      sel.addr = spi_addr_i;
      sel.data = spi_data_i;
    end
  end

  // An out-of-range address is still a completed handshake (and moves the
  // round-robin pointer), but it is dropped and only flags the error.
  assign hs      = spi_gnt || anim_gnt;
  assign addr_ok = ({1'b0, sel.addr} < NREG);
  assign push    = hs && addr_ok;
  assign err_set = hs && !addr_ok;

  // Commit gate: with sync enabled, the bank only changes during blanking.
  assign pop = (vblank_i || !sync_en_i) && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last <= REQ_ANIM;
    end else if (spi_gnt) begin
      last <= REQ_SPI;
    end else if (anim_gnt) begin
      last <= REQ_ANIM;
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr_i) begin
      err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Output register: the popped head is presented to the bank for exactly
  // one cycle. A decision in the last blanking cycle lands one cycle after
  // vblank falls, which the bank tolerates. Async reset kills an in-flight strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        wr_addr <= head.addr;
        wr_data <= head.data;
      end
    end
  end

  assign spi_ready_o  = spi_gnt;
  assign anim_ready_o = anim_gnt;
  assign wr_en_o      = wr_en;
  assign wr_addr_o    = wr_addr;
  assign wr_data_o    = wr_data;
  assign pending_o    = count;
  assign err_o        = err;

endmodule

// File: tb/tb_cfg_write_scheduler.sv
// Self-checking bench for cfg_write_scheduler: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cfg_write_scheduler;

  localparam int NREG  = 7;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_valid = 1'b0, anim_valid = 1'b0;
  logic       spi_ready, anim_ready;
  logic [2:0] spi_addr = '0, anim_addr = '0;
  logic [7:0] spi_data = '0, anim_data = '0;
  logic       vblank = 1'b0, sync_en = 1'b0, err_clr = 1'b0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] pending;
  logic       err;

  always #5 clk = ~clk;

  cfg_write_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_valid_i  (spi_valid),
    .spi_ready_o  (spi_ready),
    .spi_addr_i   (spi_addr),
    .spi_data_i   (spi_data),
    .anim_valid_i (anim_valid),
    .anim_ready_o (anim_ready),
    .anim_addr_i  (anim_addr),
    .anim_data_i  (anim_data),
    .vblank_i     (vblank),
    .sync_en_i    (sync_en),
    .err_clr_i    (err_clr),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .pending_o    (pending),
    .err_o        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  int         m_last = 1;          // 0 = SPI, 1 = ANIM
  bit         m_err  = 1'b0;
  bit         m_wen  = 1'b0;
  logic [2:0] m_wa   = '0;
  logic [7:0] m_wd   = '0;
  bit         m_full, e_spi, e_anim, m_set;
  ent_t       m_ent;
  int         strobes = 0;
  int         grant_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_last = 1; m_err = 1'b0; m_wen = 1'b0; m_wa = '0; m_wd = '0;
      chk("rst_spi_ready",  32'(spi_ready),  0);
      chk("rst_anim_ready", 32'(anim_ready), 0);
      chk("rst_wr_en",      32'(wr_en),      0);
      chk("rst_wr_addr",    32'(wr_addr),    0);
      chk("rst_wr_data",    32'(wr_data),    0);
      chk("rst_pending",    32'(pending),    0);
      chk("rst_err",        32'(err),        0);
    end else begin
      m_full = (mq.size() == DEPTH);
      e_spi  = spi_valid  && !m_full && (!anim_valid || m_last == 1);
      e_anim = anim_valid && !m_full && (!spi_valid  || m_last == 0);
      chk("m_spi_ready",  32'(spi_ready),  32'(e_spi));
      chk("m_anim_ready", 32'(anim_ready), 32'(e_anim));
      chk("m_pending",    32'(pending),    32'(mq.size()));
      chk("m_wr_en",      32'(wr_en),      32'(m_wen));
      if (m_wen) begin
        chk("m_wr_addr", 32'(wr_addr), 32'(m_wa));
        chk("m_wr_data", 32'(wr_data), 32'(m_wd));
      end
      chk("m_err", 32'(err), 32'(m_err));

      if (wr_en) strobes++;
      if (spi_valid && spi_ready)   grant_log.push_back(0);
      if (anim_valid && anim_ready) grant_log.push_back(1);

      // Next state: the bank sees queued writes in acceptance order.
      if ((vblank || !sync_en) && mq.size() > 0) begin
        m_ent = mq.pop_front();
        m_wen = 1'b1; m_wa = m_ent.a; m_wd = m_ent.d;
      end else begin
        m_wen = 1'b0;
      end
      m_set = 1'b0;
      if (e_spi || e_anim) begin
        m_ent.a = e_spi ? spi_addr : anim_addr;
        m_ent.d = e_spi ? spi_data : anim_data;
        m_last  = e_spi ? 0 : 1;
        if (32'(m_ent.a) < NREG) mq.push_back(m_ent);
        else m_set = 1'b1;
      end
      if (m_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s0;

  initial begin
    steps(2);
    chk("t0_reset_pending", 32'(pending), 0);
    rst_n = 1'b1;
    step();

    // Alternating grants under continuous contention, SPI first after reset.
    sync_en = 1'b0;
    grant_log.delete();
    spi_valid = 1'b1;  spi_addr = 3'd5;  spi_data = 8'hA5;
    anim_valid = 1'b1; anim_addr = 3'd6; anim_data = 8'h5A;
    steps(6);
    spi_valid = 1'b0; anim_valid = 1'b0;
    steps(3);
    chk("t3_grant_count", 32'(grant_log.size()), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("t3_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Single unsynchronised write: ready same cycle, strobe two cycles later.
    spi_valid = 1'b1; spi_addr = 3'd4; spi_data = 8'h3C;
    #1 chk("t1_ready", 32'(spi_ready), 1);
    step();
    spi_valid = 1'b0;
    chk("t1_pending_n1", 32'(pending), 1);
    chk("t1_wr_en_n1",   32'(wr_en),   0);
    step();
    chk("t1_wr_en_n2",   32'(wr_en),   1);
    chk("t1_wr_addr_n2", 32'(wr_addr), 4);
    chk("t1_wr_data_n2", 32'(wr_data), 32'h3C);
    step();
    chk("t1_wr_en_n3",   32'(wr_en),   0);

    // Sync mode: hold writes until vblank, then commit in order.
    sync_en = 1'b1; vblank = 1'b0;
    spi_valid = 1'b1; spi_addr = 3'd0; spi_data = 8'h11;
    step();
    spi_addr = 3'd1; spi_data = 8'h22;
    step();
    spi_valid = 1'b0;
    step();
    chk("t2_pending_held", 32'(pending), 2);
    chk("t2_no_strobe",    32'(wr_en),   0);
    vblank = 1'b1;
    step();
    chk("t2_wr1_en",   32'(wr_en),   1);
    chk("t2_wr1_addr", 32'(wr_addr), 0);
    chk("t2_wr1_data", 32'(wr_data), 32'h11);
    step();
    vblank = 1'b0;
    chk("t2_wr2_en",   32'(wr_en),   1);
    chk("t2_wr2_addr", 32'(wr_addr), 1);
    chk("t2_wr2_data", 32'(wr_data), 32'h22);
    chk("t2_pending0", 32'(pending), 0);
    step();

    // Fill the FIFO, then a single vblank pop re-opens one slot a cycle later.
    spi_valid = 1'b1;  spi_addr = 3'd2;  spi_data = 8'hA0;
    anim_valid = 1'b1; anim_addr = 3'd3; anim_data = 8'hB0;
    steps(4);
    chk("t4_full_pending", 32'(pending), 4);
    chk("t4_full_rdy",     32'(spi_ready | anim_ready), 0);
    step();
    chk("t4_held_rdy",     32'(spi_ready | anim_ready), 0);
    vblank = 1'b1;
    #1 chk("t4_pop_cycle_rdy", 32'(spi_ready | anim_ready), 0);
    step();
    vblank = 1'b0;
    chk("t4_after_pop_rdy", 32'(spi_ready | anim_ready), 1);
    chk("t4_after_pop_wr",  32'(wr_en),   1);
    chk("t4_after_pop_cnt", 32'(pending), 3);
    step();
    chk("t4_refill_cnt", 32'(pending), 4);
    chk("t4_refill_rdy", 32'(spi_ready | anim_ready), 0);
    spi_valid = 1'b0; anim_valid = 1'b0;
    vblank = 1'b1;
    steps(6);
    vblank = 1'b0;
    chk("t4_drained", 32'(pending), 0);

    // Out-of-range address: accepted, dropped, sticky error; set beats clear.
    spi_valid = 1'b1; spi_addr = 3'd7; spi_data = 8'h55;
    #1 chk("t5_ready", 32'(spi_ready), 1);
    step();
    spi_valid = 1'b0;
    chk("t5_pending", 32'(pending), 0);
    chk("t5_err_set", 32'(err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(err), 0);
    err_clr = 1'b1; spi_valid = 1'b1;
    step();
    err_clr = 1'b0; spi_valid = 1'b0;
    chk("t5_set_wins", 32'(err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();

    // Reset mid-operation with queued writes and a strobe in flight.
    sync_en = 1'b1; vblank = 1'b0;
    spi_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spi_addr = 3'(i); spi_data = 8'(8'h40 + i);
      step();
    end
    spi_valid = 1'b0;
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    chk("t6_inflight_wr", 32'(wr_en),   1);
    chk("t6_queued",      32'(pending), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_wr_drop", 32'(wr_en),   0);
    chk("t6_async_flush",   32'(pending), 0);
    step();
    rst_n = 1'b1;
    s0 = strobes;
    vblank = 1'b1;
    steps(5);
    vblank = 1'b0;
    chk("t6_no_stale_strobe", 32'(strobes - s0), 0);
    chk("t6_pending_after",   32'(pending), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
